// File: rtl/ssb_scan_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ssb_scan_pkg
// Description : Shared widths, column selector encoding and comparator modes
//               for the SSB column-scan predicate engine.
// Contents    : CL_BITS, code widths, codes-per-line counts, scan_col_e,
//               cmp_mode_e.
// Revision    : 1.0 - initial release
// ============================================================================
package ssb_scan_pkg;

  localparam int CL_BITS       = 512;
  localparam int PRED_BITS     = 8;
  localparam int COL_SEL_BITS  = 2;

  // Code widths for the packed columns
  localparam int CODE4_BITS    = 4;
  localparam int CODE8_BITS    = 8;

  // Codes per 512-bit cache line for each width
  localparam int CODES4_PER_CL = CL_BITS / CODE4_BITS;  // 128
  localparam int CODES8_PER_CL = CL_BITS / CODE8_BITS;  // 64

  // Column selector; value 3 is unused and produces an empty bitmap
  typedef enum logic [COL_SEL_BITS-1:0] {
    COL_D_YEAR      = 2'd0,
    COL_LO_DISCOUNT = 2'd1,
    COL_LO_QUANTITY = 2'd2
  } scan_col_e;

  // Per-code comparison mode
  typedef enum logic [1:0] {
    CMP_EQ    = 2'd0,  // code == lower
    CMP_RANGE = 2'd1,  // lower <= code <= upper
    CMP_LT    = 2'd2   // code <  lower
  } cmp_mode_e;

endpackage
`default_nettype wire

// File: rtl/ssb_scan_filter_if.sv
`default_nettype none
// ============================================================================
// Module      : ssb_scan_filter_if
// Description : Bus between the scan controller and the column-scan filter.
// Signals     : en              - process cl_data this cycle
//               scan_column     - column select (0 year, 1 discount, 2 qty)
//               filter_pred     - predicate byte, layout depends on column
//               cl_data         - 512-bit packed cache line
//               bit_result      - registered match bitmap
//               processing_done - registered result-valid level
// Modports    : master (scan controller), slave (filter)
// Revision    : 1.0 - initial release
// ============================================================================
interface ssb_scan_filter_if;
  import ssb_scan_pkg::*;

  logic                    en;
  logic [COL_SEL_BITS-1:0] scan_column;
  logic [PRED_BITS-1:0]    filter_pred;
  logic [CL_BITS-1:0]      cl_data;
  logic [CL_BITS-1:0]      bit_result;
  logic                    processing_done;

  modport master (
    output en, scan_column, filter_pred, cl_data,
    input  bit_result, processing_done
  );

  modport slave (
    input  en, scan_column, filter_pred, cl_data,
    output bit_result, processing_done
  );

endinterface
`default_nettype wire

// File: rtl/ssb_scan_filter_code_compare.sv
`default_nettype none
// ============================================================================
// Module      : ssb_code_compare
// Description : Combinational single-code predicate comparator.
// Parameters  : CODE_W  - code width in bits
// Ports       : code_i  - packed column code
//               lower_i - equality value / lower bound / less-than limit
//               upper_i - upper bound (RANGE mode only)
//               mode_i  - comparison mode (EQ / RANGE / LT)
//               match_o - 1 when the code satisfies the predicate
// Revision    : 1.0 - initial release
// ============================================================================
module ssb_code_compare
  import ssb_scan_pkg::*;
#(
  parameter int CODE_W = 4
) (
  input  logic [CODE_W-1:0] code_i,
  input  logic [CODE_W-1:0] lower_i,
  input  logic [CODE_W-1:0] upper_i,
  input  cmp_mode_e         mode_i,
  output logic              match_o
);

  always_comb begin
    match_o = 1'b0;
    case (mode_i)
      CMP_EQ:    match_o = (code_i == lower_i);
      // An inverted range (lower > upper) is empty by construction.
      CMP_RANGE: match_o = (code_i >= lower_i) && (code_i <= upper_i);
      CMP_LT:    match_o = (code_i <  lower_i);
      default:   match_o = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ssb_scan_filter.sv
`default_nettype none
// ============================================================================
// Module      : ssb_scan_filter
// Description : Column-scan predicate engine. Evaluates one predicate against
//               every packed code of a 512-bit cache line and captures the
//               match bitmap once per line.
// Ports       : clk   - system clock
//               reset - synchronous active-high; clears result and done
//               bus   - ssb_scan_filter_if.slave (en, scan_column,
//                       filter_pred, cl_data, bit_result, processing_done)
// Revision    : 1.0 - initial release
// ============================================================================
module ssb_scan_filter
  import ssb_scan_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  ssb_scan_filter_if.slave   bus
);

  // The 8-bit comparators only run in LT mode; their upper bound is unused.
  localparam logic [CODE8_BITS-1:0] C_UPPER8_UNUSED = '1;

  logic [CODES4_PER_CL-1:0] nib_match;
  logic [CODES8_PER_CL-1:0] byte_match;
  cmp_mode_e                nib_mode;
  logic [CL_BITS-1:0]       bitmap;

  logic [CL_BITS-1:0]       bit_result_q, bit_result_d;
  logic                     done_q, done_d;

  // d_year and lo_discount share the 4-bit comparator bank; only the mode
  // differs. For other columns the 4-bit bank output is simply not selected.
  always_comb begin
    nib_mode = CMP_RANGE;
    if (bus.scan_column == COL_D_YEAR) begin
      nib_mode = CMP_EQ;
    end
  end

  generate
    for (genvar gi = 0; gi < CODES4_PER_CL; gi++) begin : g_nib_cmp
      ssb_code_compare #(
        .CODE_W (CODE4_BITS)
      ) u_cmp (
        .code_i  (bus.cl_data[CODE4_BITS*gi +: CODE4_BITS]),
        .lower_i (bus.filter_pred[3:0]),
        .upper_i (bus.filter_pred[7:4]),
        .mode_i  (nib_mode),
        .match_o (nib_match[gi])
      );
    end

    for (genvar gj = 0; gj < CODES8_PER_CL; gj++) begin : g_byte_cmp
      ssb_code_compare #(
        .CODE_W (CODE8_BITS)
      ) u_cmp (
        .code_i  (bus.cl_data[CODE8_BITS*gj +: CODE8_BITS]),
        .lower_i (bus.filter_pred),
        .upper_i (C_UPPER8_UNUSED),
        .mode_i  (CMP_LT),
        .match_o (byte_match[gj])
      );
    end
  endgenerate

  // Column bitmap select; unused upper bits are zero-filled.
  always_comb begin
    bitmap = '0;
    case (bus.scan_column)
      COL_D_YEAR,
      COL_LO_DISCOUNT: bitmap[CODES4_PER_CL-1:0] = nib_match;
      COL_LO_QUANTITY: bitmap[CODES8_PER_CL-1:0] = byte_match;
      default:         bitmap = '0;
    endcase
  end

  // Capture once: the first en while not done loads the bitmap; after that
  // result and done hold regardless of en or input changes until reset.
  always_comb begin
    bit_result_d = bit_result_q;
    done_d       = done_q;
    if (bus.en && !done_q) begin
      bit_result_d = bitmap;
      done_d       = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_result_q <= '0;
      done_q       <= 1'b0;
    end else begin
      bit_result_q <= bit_result_d;
      done_q       <= done_d;
    end
  end

  assign bus.bit_result      = bit_result_q;
  assign bus.processing_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ssb_scan_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssb_scan_filter
// Description : Self-checking bench for ssb_scan_filter with a behavioural
//               per-code reference model and randomized lines.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssb_scan_filter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  ssb_scan_filter_if bus ();

  ssb_scan_filter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: walk every code of the line and apply the column's rule.
  function automatic logic [511:0] model(input int col, input logic [7:0] pred,
                                         input logic [511:0] d);
    logic [511:0] r;
    int code;
    int lo;
    int hi;
    r  = '0;
    lo = int'(pred[3:0]);
    hi = int'(pred[7:4]);
    if (col == 0) begin
      for (int i = 0; i < 128; i++) begin
        code = int'(d[4*i +: 4]);
        r[i] = (code == lo);
      end
    end else if (col == 1) begin
      for (int i = 0; i < 128; i++) begin
        code = int'(d[4*i +: 4]);
        r[i] = (lo <= code) && (code <= hi);
      end
    end else if (col == 2) begin
      for (int i = 0; i < 64; i++) begin
        code = int'(d[8*i +: 8]);
        r[i] = (code < int'(pred));
      end
    end
    return r;
  endfunction

  function automatic logic [511:0] rand_line();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    bus.en = 1'b0;
    @(negedge clk);
    reset  = 1'b0;
  endtask

  // Apply inputs with en for one edge; outputs are sampled #1 after it.
  task automatic capture(input logic [1:0] col, input logic [7:0] pred,
                         input logic [511:0] d);
    @(negedge clk);
    bus.scan_column = col;
    bus.filter_pred = pred;
    bus.cl_data     = d;
    bus.en          = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    bus.en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(posedge clk); #1;
    checks++;
    if (bus.bit_result !== '0 || bus.processing_done !== 1'b0) begin
      errors++;
      $display("FAIL reset: result=%h done=%b required result=0 done=0",
               bus.bit_result, bus.processing_done);
    end
  endtask

  task automatic test_d_year();
    logic [511:0] d;
    logic [511:0] req;
    d = {128{4'h3}};
    d[23:20] = 4'h6;
    req = 512'h20;
    do_reset();
    capture(2'd0, 8'h06, d);
    checks++;
    if (bus.bit_result !== req || bus.processing_done !== 1'b1) begin
      errors++;
      $display("FAIL d_year: result=%h done=%b required result=%h done=1",
               bus.bit_result, bus.processing_done, req);
    end
  endtask

  task automatic test_lo_discount();
    logic [511:0] d;
    logic [511:0] req;
    for (int i = 0; i < 128; i++) d[4*i +: 4] = 4'(i % 16);
    req = model(1, 8'h31, d);
    do_reset();
    capture(2'd1, 8'h31, d);
    checks++;
    if (bus.bit_result !== req) begin
      errors++;
      $display("FAIL discount_range: result=%h required=%h", bus.bit_result, req);
    end
    checks++;
    if (bus.bit_result[1] !== 1'b1 || bus.bit_result[4] !== 1'b0 ||
        bus.bit_result[17] !== 1'b1 || bus.bit_result[511:128] !== '0) begin
      errors++;
      $display("FAIL discount_bits: b1=%b b4=%b b17=%b hi=%h required 1 0 1 0",
               bus.bit_result[1], bus.bit_result[4], bus.bit_result[17],
               bus.bit_result[511:128]);
    end
    // Inverted bounds: lower 5, higher 2
    do_reset();
    capture(2'd1, 8'h25, d);
    checks++;
    if (bus.bit_result !== '0 || bus.processing_done !== 1'b1) begin
      errors++;
      $display("FAIL discount_empty: result=%h done=%b required result=0 done=1",
               bus.bit_result, bus.processing_done);
    end
  endtask

  task automatic test_lo_quantity();
    logic [511:0] d;
    logic [511:0] req;
    for (int i = 0; i < 64; i++) d[8*i +: 8] = 8'(i);
    req = 512'h01FF_FFFF;
    do_reset();
    capture(2'd2, 8'd25, d);
    checks++;
    if (bus.bit_result !== req || bus.processing_done !== 1'b1) begin
      errors++;
      $display("FAIL quantity: result=%h done=%b required result=%h done=1",
               bus.bit_result, bus.processing_done, req);
    end
  endtask

  task automatic test_hold();
    logic [511:0] d;
    logic [511:0] held;
    d = rand_line();
    held = model(0, 8'h07, d);
    do_reset();
    capture(2'd0, 8'h07, d);
    checks++;
    if (bus.bit_result !== held) begin
      errors++;
      $display("FAIL hold_capture: result=%h required=%h", bus.bit_result, held);
    end
    // en high with different data for 3 cycles: ignored
    @(negedge clk);
    bus.cl_data     = '0;
    bus.scan_column = 2'd2;
    bus.filter_pred = 8'hFF;
    bus.en          = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.bit_result !== held || bus.processing_done !== 1'b1) begin
        errors++;
        $display("FAIL hold_ignore cyc%0d: result=%h done=%b required result=%h done=1",
                 k, bus.bit_result, bus.processing_done, held);
      end
    end
    // en deasserted: still held
    @(negedge clk);
    bus.en = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.bit_result !== held || bus.processing_done !== 1'b1) begin
      errors++;
      $display("FAIL hold_en_low: result=%h done=%b required result=%h done=1",
               bus.bit_result, bus.processing_done, held);
    end
    // Reset alone
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.bit_result !== '0 || bus.processing_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: result=%h done=%b required result=0 done=0",
               bus.bit_result, bus.processing_done);
    end
    // Reset and en together: reset wins
    @(negedge clk);
    bus.en = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.bit_result !== '0 || bus.processing_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_with_en: result=%h done=%b required result=0 done=0",
               bus.bit_result, bus.processing_done);
    end
    // Release reset with en low: no capture happens
    @(negedge clk);
    reset  = 1'b0;
    bus.en = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.processing_done !== 1'b0) begin
      errors++;
      $display("FAIL no_en_no_capture: done=%b required=0", bus.processing_done);
    end
    // New capture needs en again
    d = rand_line();
    capture(2'd2, 8'h80, d);
    checks++;
    if (bus.bit_result !== model(2, 8'h80, d) || bus.processing_done !== 1'b1) begin
      errors++;
      $display("FAIL recapture: result=%h done=%b required result=%h done=1",
               bus.bit_result, bus.processing_done, model(2, 8'h80, d));
    end
  endtask

  task automatic test_column3();
    do_reset();
    capture(2'd3, 8'($urandom), rand_line());
    checks++;
    if (bus.bit_result !== '0 || bus.processing_done !== 1'b1) begin
      errors++;
      $display("FAIL column3: result=%h done=%b required result=0 done=1",
               bus.bit_result, bus.processing_done);
    end
  endtask

  task automatic test_random();
    logic [511:0] d;
    logic [511:0] req;
    logic [7:0]   pred;
    int           col;
    for (int n = 0; n < 60; n++) begin
      col  = int'($urandom_range(0, 3));
      pred = 8'($urandom);
      d    = rand_line();
      // Bias some 4-bit lines toward few distinct values so matches are dense
      if (n % 3 == 0) begin
        for (int i = 0; i < 128; i++) d[4*i +: 4] = 4'($urandom_range(0, 3) + 4);
      end
      req = model(col, pred, d);
      do_reset();
      capture(2'(col), pred, d);
      checks++;
      if (bus.bit_result !== req || bus.processing_done !== 1'b1) begin
        errors++;
        $display("FAIL random[%0d] col=%0d pred=%h: result=%h done=%b required=%h",
                 n, col, pred, bus.bit_result, bus.processing_done, req);
      end
    end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    reset           = 1'b1;
    bus.en          = 1'b0;
    bus.scan_column = 2'd0;
    bus.filter_pred = 8'h00;
    bus.cl_data     = '0;
    test_reset();
    test_d_year();
    test_lo_discount();
    test_lo_quantity();
    test_hold();
    test_column3();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
